sisc_ctrl_mc: RTL and testbench

//  Parametrised multicycle control FSM for the SISC datapath; next generation of the basic fetch/decode/execute/mem/writeback controller.

---
 rtl/sisc_ctrl_mc.sv | 192 +++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_mc.sv
// Multicycle control FSM for the SISC datapath: fetch/decode/execute,
// memory sequencing with req/ack and timeout, two-step SWP writeback,
// resumable HALT and sticky ERROR on memory timeout.
//
// Ports:
//   clk, rst_f           clock, async active-low reset
//   opcode, mm, stat     IR opcode/mode fields and status flags
//   mem_ack, run         memory completion, resume pulse (HALT only)
//   rf_we, wb_sel        register-file write enable / source
//   alu_op, rb_sel       ALU function, read-port-B select
//   pc_sel, br_sel       PC source, branch target mode
//   pc_write, pc_rst     PC write enable / reset
//   ir_load              IR load enable
//   mem_req, mem_we      data-memory request / write
//   halted, err          in HALT / sticky timeout flag
module sisc_ctrl_mc #(
   parameter int OP_W    = 4,
   parameter int CC_W    = 4,
   parameter int ALUOP_W = 2,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic [OP_W-1:0]    opcode,
   input  logic [CC_W-1:0]    mm,
   input  logic [CC_W-1:0]    stat,
   input  logic               mem_ack,
   input  logic               run,
   output logic               rf_we,
   output logic [1:0]         wb_sel,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               rb_sel,
   output logic               pc_sel,
   output logic               br_sel,
   output logic               pc_write,
   output logic               pc_rst,
   output logic               ir_load,
   output logic               mem_req,
   output logic               mem_we,
   output logic               halted,
   output logic               err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
   localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SWP = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
   localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
   localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);
   localparam logic [CC_W-1:0] MM_IMM = CC_W'(8);

   typedef enum logic [3:0] {
      S_START0, S_START1, S_FETCH, S_DECODE, S_EXECUTE,
      S_MEM, S_WB, S_WB2, S_HALT, S_ERROR
   } state_t;

   state_t          state;
   logic [OP_W-1:0] op_q;
   logic [CC_W-1:0] mm_q;
   logic [CC_W-1:0] mm_v;
   logic [OP_W-1:0] op;
   logic [CW-1:0]   wcnt;
   logic            err_q;

   // DECODE works on the freshly loaded IR; later states use the copy
   // captured when leaving DECODE.
   assign op   = (state == S_DECODE) ? opcode : op_q;
   assign mm_v = (state == S_DECODE) ? mm : mm_q;

   logic is_lod, is_str, is_swp, is_alu, is_hlt;
   logic is_bra, is_brr, is_bne, is_bnr;
   logic is_br, is_exe, cc_hit, taken, imm;

   assign is_lod = (op == OP_LOD);
   assign is_str = (op == OP_STR);
   assign is_swp = (op == OP_SWP);
   assign is_alu = (op == OP_ALU);
   assign is_hlt = (op == OP_HLT);
   assign is_bra = (op == OP_BRA);
   assign is_brr = (op == OP_BRR);
   assign is_bne = (op == OP_BNE);
   assign is_bnr = (op == OP_BNR);
   assign is_br  = is_bra | is_brr | is_bne | is_bnr;
   assign is_exe = is_lod | is_str | is_swp | is_alu;
   assign imm    = (mm_v == MM_IMM);
   assign cc_hit = |(stat & mm_v);
   // Positive-sense branches take on any flag hit, negated ones on none.
   assign taken  = ((is_bra | is_brr) & cc_hit)
                 | ((is_bne | is_bnr) & ~cc_hit);

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state <= S_START0;
         op_q  <= '0;
         mm_q  <= '0;
         wcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         unique case (state)
            S_START0: state <= S_START1;
            S_START1: state <= S_FETCH;
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               op_q <= opcode;
               mm_q <= mm;
               if (is_hlt)      state <= S_HALT;
               else if (is_exe) state <= S_EXECUTE;
               else             state <= S_FETCH;
            end
            S_EXECUTE: begin
               wcnt <= '0;
               if (is_lod | is_str) state <= S_MEM;
               else                 state <= S_WB;
            end
            S_MEM: begin
               // An ack on the last allowed cycle still completes.
               if (mem_ack) begin
                  wcnt  <= '0;
                  state <= is_str ? S_FETCH : S_WB;
               end else if (wcnt == CW'(TIMEOUT - 1)) begin
                  err_q <= 1'b1;
                  state <= S_ERROR;
               end else begin
                  wcnt <= wcnt + CW'(1);
               end
            end
            S_WB:   state <= is_swp ? S_WB2 : S_FETCH;
            S_WB2:  state <= S_FETCH;
            S_HALT: if (run) state <= S_FETCH;
            S_ERROR: state <= S_ERROR;
            default: state <= S_START0;
         endcase
      end
   end

   always_comb begin
      rf_we    = 1'b0;
      wb_sel   = 2'd0;
      alu_op   = '0;
      rb_sel   = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      pc_write = 1'b0;
      pc_rst   = 1'b0;
      ir_load  = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      halted   = 1'b0;
      err      = err_q;
      unique case (state)
         S_START0: pc_rst = 1'b1;
         S_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         S_DECODE: begin
            br_sel = is_brr | is_bnr;
            if (is_br && taken) begin
               pc_sel   = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_EXECUTE: begin
            if (is_alu) alu_op = imm ? ALUOP_W'(1) : ALUOP_W'(0);
            else        alu_op = imm ? ALUOP_W'(3) : ALUOP_W'(2);
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_str;
            rb_sel  = is_str;
         end
         S_WB: begin
            rf_we = 1'b1;
            if (is_lod)      wb_sel = 2'd1;
            else if (is_swp) wb_sel = 2'd2;
            else             wb_sel = 2'd0;
         end
         S_WB2: begin
            rf_we  = 1'b1;
            wb_sel = 2'd3;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Self-checking bench for sisc_ctrl_mc: per-cycle expected output words
// queued by the driver, popped and compared on the falling edge.
module tb_sisc_ctrl_mc;

   logic       clk = 1'b0;
   logic       rst_f = 1'b0;
   logic [3:0] opcode = '0;
   logic [3:0] mm = '0;
   logic [3:0] stat = '0;
   logic       mem_ack = 1'b0;
   logic       run = 1'b0;
   logic       rf_we, rb_sel, pc_sel, br_sel, pc_write, pc_rst;
   logic       ir_load, mem_req, mem_we, halted, err;
   logic [1:0] wb_sel, alu_op;

   sisc_ctrl_mc #(
      .OP_W(4), .CC_W(4), .ALUOP_W(2), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm),
      .stat(stat), .mem_ack(mem_ack), .run(run),
      .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
      .rb_sel(rb_sel), .pc_sel(pc_sel), .br_sel(br_sel),
      .pc_write(pc_write), .pc_rst(pc_rst), .ir_load(ir_load),
      .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
      .err(err)
   );

   always #5 clk = ~clk;

   // Output word: rf_we wb_sel alu_op rb_sel pc_sel br_sel pc_write
   // pc_rst ir_load mem_req mem_we halted err
   typedef logic [14:0] outs_t;
   localparam outs_t Z   = 15'h0;
   localparam outs_t RF  = 15'h4000;
   localparam outs_t WB1 = 15'h1000;
   localparam outs_t WB2 = 15'h2000;
   localparam outs_t WB3 = 15'h3000;
   localparam outs_t AL1 = 15'h0400;
   localparam outs_t AL2 = 15'h0800;
   localparam outs_t AL3 = 15'h0C00;
   localparam outs_t RB  = 15'h0200;
   localparam outs_t PS  = 15'h0100;
   localparam outs_t BS  = 15'h0080;
   localparam outs_t PW  = 15'h0040;
   localparam outs_t PR  = 15'h0020;
   localparam outs_t IR  = 15'h0010;
   localparam outs_t MR  = 15'h0008;
   localparam outs_t MW  = 15'h0004;
   localparam outs_t HL  = 15'h0002;
   localparam outs_t ER  = 15'h0001;
   localparam outs_t F   = PW | IR;
   localparam outs_t MST = MR | MW | RB;

   outs_t act;
   assign act = {rf_we, wb_sel, alu_op, rb_sel, pc_sel, br_sel,
                 pc_write, pc_rst, ir_load, mem_req, mem_we,
                 halted, err};

   int errors = 0;
   int checks = 0;

   outs_t exp_q[$];
   string nm_q[$];

   typedef struct {
      string      nm;
      logic [3:0] op;
      logic [3:0] mm;
      logic [3:0] st;
      int         n;
      logic [5:0] ack;
      logic [5:0][14:0] seq;
   } vec_t;

   vec_t tbl[$];

   task automatic compare(input outs_t e, input string nm);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, e);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         outs_t e;
         string n;
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         compare(e, n);
      end
   end

   task automatic cyc(input outs_t e, input string nm,
                      input logic ack, input logic rn);
      @(posedge clk);
      #1;
      mem_ack = ack;
      run     = rn;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic add(input string nm, input logic [3:0] op,
                      input logic [3:0] m, input logic [3:0] st,
                      input int n, input logic [5:0] ack,
                      input outs_t s0, input outs_t s1,
                      input outs_t s2, input outs_t s3,
                      input outs_t s4);
      vec_t v;
      v.nm  = nm;
      v.op  = op;
      v.mm  = m;
      v.st  = st;
      v.n   = n;
      v.ack = ack;
      v.seq = {Z, s4, s3, s2, s1, s0};
      tbl.push_back(v);
   endtask

   task automatic fetch(input logic [3:0] op, input logic [3:0] m,
                        input logic [3:0] st, input string nm);
      cyc(F, {nm, "_fetch"}, 1'b0, 1'b0);
      opcode = op;
      mm     = m;
      stat   = st;
   endtask

   // Reset is already low here; check START0, release, check START1.
   task automatic start_up(input string nm);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      run     = 1'b0;
      exp_q.push_back(PR);
      nm_q.push_back({nm, "_start0"});
      #2;
      rst_f = 1'b1;
      cyc(Z, {nm, "_start1"}, 1'b0, 1'b0);
   endtask

   task automatic async_reset(input string nm);
      @(negedge clk);
      #2;
      rst_f = 1'b0;
      #1;
      compare(PR, nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      add("nop",     4'd0,  4'd0, 4'd0, 2, 6'b0, F, Z,        Z, Z, Z);
      add("bra_t",   4'd4,  4'd2, 4'd2, 2, 6'b0, F, PS|PW,    Z, Z, Z);
      add("bra_nt",  4'd4,  4'd2, 4'd4, 2, 6'b0, F, Z,        Z, Z, Z);
      add("brr_t",   4'd5,  4'd1, 4'd3, 2, 6'b0, F, PS|PW|BS, Z, Z, Z);
      add("brr_nt",  4'd5,  4'd8, 4'd7, 2, 6'b0, F, BS,       Z, Z, Z);
      add("bne_nt",  4'd6,  4'd2, 4'd2, 2, 6'b0, F, Z,        Z, Z, Z);
      add("bne_t",   4'd6,  4'd4, 4'd2, 2, 6'b0, F, PS|PW,    Z, Z, Z);
      add("bnr_nt",  4'd7,  4'd2, 4'd2, 2, 6'b0, F, BS,       Z, Z, Z);
      add("bnr_t",   4'd7,  4'd1, 4'd2, 2, 6'b0, F, PS|PW|BS, Z, Z, Z);
      add("bad_op",  4'd12, 4'hF, 4'hF, 2, 6'b0, F, Z,        Z, Z, Z);
      add("alu_imm", 4'd8,  4'd8, 4'd0, 4, 6'b0, F, Z, AL1, RF, Z);
      add("alu_rr",  4'd8,  4'd3, 4'd0, 4, 6'b0, F, Z, Z,   RF, Z);
      add("swp",     4'd3,  4'd0, 4'd0, 5, 6'b0,
          F, Z, AL2, RF|WB2, RF|WB3);
      add("swp_imm", 4'd3,  4'd8, 4'd0, 5, 6'b0,
          F, Z, AL3, RF|WB2, RF|WB3);
      add("lod0",    4'd1,  4'd8, 4'd0, 5, 6'b001000,
          F, Z, AL3, MR, RF|WB1);
      add("str0",    4'd2,  4'd0, 4'd0, 4, 6'b001000,
          F, Z, AL2, MST, Z);

      start_up("por");

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            cyc(tbl[i].seq[k], $sformatf("%s[%0d]", tbl[i].nm, k),
                tbl[i].ack[k], 1'b0);
            if (k == 0) begin
               opcode = tbl[i].op;
               mm     = tbl[i].mm;
               stat   = tbl[i].st;
            end
         end
      end

      // LOD with three wait cycles before ack
      fetch(4'd1, 4'd0, 4'd0, "lod3");
      cyc(Z,   "lod3_dec", 1'b0, 1'b0);
      cyc(AL2, "lod3_exe", 1'b0, 1'b0);
      for (int w = 0; w < 3; w++)
         cyc(MR, $sformatf("lod3_wait%0d", w), 1'b0, 1'b0);
      cyc(MR,     "lod3_ack", 1'b1, 1'b0);
      cyc(RF|WB1, "lod3_wb",  1'b0, 1'b0);

      // HLT, opcode churn while halted, resume with run
      fetch(4'd15, 4'd0, 4'd0, "hlt");
      cyc(Z,  "hlt_dec", 1'b0, 1'b0);
      cyc(HL, "hlt_0",   1'b0, 1'b0);
      opcode = 4'd8;
      cyc(HL, "hlt_1",   1'b0, 1'b0);
      cyc(HL, "hlt_run", 1'b0, 1'b1);
      cyc(F,  "hlt_resume_fetch", 1'b0, 1'b0);
      opcode = 4'd0;
      cyc(Z,  "hlt_resume_dec", 1'b0, 1'b0);

      // STR acked on the final allowed MEM cycle: ack beats timeout
      fetch(4'd2, 4'd0, 4'd0, "str16");
      cyc(Z,   "str16_dec", 1'b0, 1'b0);
      cyc(AL2, "str16_exe", 1'b0, 1'b0);
      for (int w = 0; w < 15; w++)
         cyc(MST, $sformatf("str16_wait%0d", w), 1'b0, 1'b0);
      cyc(MST, "str16_ack", 1'b1, 1'b0);

      // STR never acked: ERROR after 16 MEM cycles, sticky
      fetch(4'd2, 4'd0, 4'd0, "sto");
      cyc(Z,   "sto_dec", 1'b0, 1'b0);
      cyc(AL2, "sto_exe", 1'b0, 1'b0);
      for (int w = 0; w < 16; w++)
         cyc(MST, $sformatf("sto_mem%0d", w), 1'b0, 1'b0);
      cyc(ER, "sto_err0", 1'b1, 1'b0);
      cyc(ER, "sto_err1", 1'b0, 1'b1);
      cyc(ER, "sto_err2", 1'b0, 1'b0);
      async_reset("sto_reset_clears_err");
      start_up("after_err");

      // Async reset in the middle of a MEM wait
      fetch(4'd2, 4'd0, 4'd0, "rmid");
      cyc(Z,   "rmid_dec", 1'b0, 1'b0);
      cyc(AL2, "rmid_exe", 1'b0, 1'b0);
      cyc(MST, "rmid_mem0", 1'b0, 1'b0);
      cyc(MST, "rmid_mem1", 1'b0, 1'b0);
      async_reset("rmid_reset");
      start_up("after_rmid");
      fetch(4'd8, 4'd8, 4'd0, "post");
      cyc(Z,      "post_dec", 1'b0, 1'b0);
      cyc(AL1,    "post_exe", 1'b0, 1'b0);
      cyc(RF,     "post_wb",  1'b0, 1'b0);
      cyc(F,      "post_fetch", 1'b0, 1'b0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d left required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
